// File: rtl/led_bar_arbiter.sv
// Arbitrates the 10-LED bar between the VU meter, a timed parameter readout
// and a clip-warning flash, with priority CLIP > PARAM > METER.
module led_bar_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned FLASH_CYCLES = 6_250_000,
  parameter int unsigned FLASH_COUNT  = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [9:0] vu_level,
  input  logic       param_req,
  input  logic [3:0] param_value,
  output logic       param_ack,
  output logic [9:0] led_out,
  output logic [1:0] display_src
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam int unsigned PW = $clog2(2 * FLASH_COUNT);

  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(2 * FLASH_COUNT - 1);

  typedef enum logic [1:0] {
    SRC_METER = 2'd0,
    SRC_PARAM = 2'd1,
    SRC_CLIP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   holdCnt_q, holdCnt_d;
  logic [FW-1:0]   flashCnt_q, flashCnt_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [3:0]      value_q, value_d;
  logic            vu9_q;
  logic            ack_q;
  logic [9:0]      led_q, led_d;
  logic [1:0]      src_q, src_d;

  logic            clipEdge;
  logic            accept;
  logic            holdDone;
  logic            clipDone;
  logic [3:0]      paramSat;
  logic [9:0]      paramBar;

  // An accepted request is masked for the ack cycle, so a held request re-accepts every 2 cycles.
  assign clipEdge = vu_level[9] & ~vu9_q;
  assign accept   = param_req & ~ack_q & (state_q != SRC_CLIP) & ~clipEdge;
  assign holdDone = (holdCnt_q == HOLD_LAST);
  assign clipDone = (flashCnt_q == FLASH_LAST) && (phase_q == PHASE_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SRC_METER;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SRC_METER: begin
        if (clipEdge)    state_d = SRC_CLIP;
        else if (accept) state_d = SRC_PARAM;
      end
      SRC_PARAM: begin
        if (clipEdge)      state_d = SRC_CLIP;
        else if (accept)   state_d = SRC_PARAM;
        else if (holdDone) state_d = SRC_METER;
      end
      SRC_CLIP: begin
        if (clipDone) state_d = SRC_METER;
      end
      default: state_d = SRC_METER;
    endcase
  end

  always_comb begin
    holdCnt_d  = holdCnt_q;
    flashCnt_d = flashCnt_q;
    phase_d    = phase_q;
    value_d    = value_q;
    case (state_q)
      SRC_METER, SRC_PARAM: begin
        if (clipEdge) begin
          flashCnt_d = '0;
          phase_d    = '0;
        end else if (accept) begin
          value_d   = param_value;
          holdCnt_d = '0;
        end else if (state_q == SRC_PARAM) begin
          holdCnt_d = holdDone ? '0 : holdCnt_q + HW'(1);
        end
      end
      SRC_CLIP: begin
        if (flashCnt_q == FLASH_LAST) begin
          flashCnt_d = '0;
          phase_d    = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
        end else begin
          flashCnt_d = flashCnt_q + FW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    paramSat = (value_q > 4'd10) ? 4'd10 : value_q;
    paramBar = '0;
    for (int i = 0; i < 10; i++) begin
      paramBar[i] = (4'(i) < paramSat);
    end
  end

  always_comb begin
    led_d = vu_level;
    src_d = state_q;
    case (state_q)
      SRC_METER: led_d = vu_level;
      SRC_PARAM: led_d = paramBar;
      SRC_CLIP:  led_d = phase_q[0] ? 10'h000 : 10'h3FF;
      default:   led_d = 10'h000;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      holdCnt_q  <= '0;
      flashCnt_q <= '0;
      phase_q    <= '0;
      value_q    <= '0;
      vu9_q      <= 1'b0;
      ack_q      <= 1'b0;
      led_q      <= '0;
      src_q      <= '0;
    end else begin
      holdCnt_q  <= holdCnt_d;
      flashCnt_q <= flashCnt_d;
      phase_q    <= phase_d;
      value_q    <= value_d;
      vu9_q      <= vu_level[9];
      ack_q      <= accept;
      led_q      <= led_d;
      src_q      <= src_d;
    end
  end

  assign param_ack   = ack_q;
  assign led_out     = led_q;
  assign display_src = src_q;

endmodule

// File: tb/tb_led_bar_arbiter.sv
// Directed bench for led_bar_arbiter with HOLD_CYCLES=8, FLASH_CYCLES=4,
// FLASH_COUNT=2; expected values are hand-computed per step.
module tb_led_bar_arbiter;

  logic       clock;
  logic       reset_n;
  logic [9:0] vu_level;
  logic       param_req;
  logic [3:0] param_value;
  logic       param_ack;
  logic [9:0] led_out;
  logic [1:0] display_src;

  int errors = 0;
  int checks = 0;

  led_bar_arbiter #(
    .HOLD_CYCLES (8),
    .FLASH_CYCLES(4),
    .FLASH_COUNT (2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .vu_level   (vu_level),
    .param_req  (param_req),
    .param_value(param_value),
    .param_ack  (param_ack),
    .led_out    (led_out),
    .display_src(display_src)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic [9:0] vu, input logic req, input logic [3:0] val);
    vu_level    = vu;
    param_req   = req;
    param_value = val;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] expLed,
                             input logic [1:0] expSrc, input logic expAck);
    checks++;
    assert (led_out === expLed) else begin
      errors++;
      $error("[TB] FAIL %s led_out: got %h expected %h", tag, led_out, expLed);
    end
    checks++;
    assert (display_src === expSrc) else begin
      errors++;
      $error("[TB] FAIL %s display_src: got %0d expected %0d", tag, display_src, expSrc);
    end
    checks++;
    assert (param_ack === expAck) else begin
      errors++;
      $error("[TB] FAIL %s param_ack: got %b expected %b", tag, param_ack, expAck);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(10'h0FF, 1'b0, 4'd0);
    tick();
    tick();
    checkOutput("reset_hold", 10'h000, 2'd0, 1'b0);

    reset_n = 1'b1;
    tick();
    checkOutput("reset_release", 10'h0FF, 2'd0, 1'b0);

    // Single request, value 4: eight cycles of 00F after the ack cycle.
    applyStimulus(10'h0FF, 1'b1, 4'd4);
    tick();
    checkOutput("single_ack", 10'h0FF, 2'd0, 1'b1);
    applyStimulus(10'h03F, 1'b0, 4'd4);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("single_hold%0d", i), 10'h00F, 2'd1, 1'b0);
    end
    tick();
    checkOutput("single_revert", 10'h03F, 2'd0, 1'b0);

    // Saturation to 10 LEDs, then retrigger with value 2 at hold count 5.
    applyStimulus(10'h03F, 1'b1, 4'd13);
    tick();
    checkOutput("sat_ack", 10'h03F, 2'd0, 1'b1);
    applyStimulus(10'h03F, 1'b0, 4'd13);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("sat_hold%0d", i), 10'h3FF, 2'd1, 1'b0);
    end
    applyStimulus(10'h03F, 1'b1, 4'd2);
    tick();
    checkOutput("retrig_ack", 10'h3FF, 2'd1, 1'b1);
    applyStimulus(10'h03F, 1'b0, 4'd2);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("retrig_hold%0d", i), 10'h003, 2'd1, 1'b0);
    end
    tick();
    checkOutput("retrig_revert", 10'h03F, 2'd0, 1'b0);

    // Clip flash with a second rising edge mid-flash that must not extend it.
    applyStimulus(10'h1FF, 1'b0, 4'd0);
    tick();
    checkOutput("clip_pre", 10'h1FF, 2'd0, 1'b0);
    applyStimulus(10'h3FF, 1'b0, 4'd0);
    tick();
    checkOutput("clip_edge", 10'h3FF, 2'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 4) vu_level = 10'h1FF;
      if (i == 5) vu_level = 10'h3FF;
      tick();
      checkOutput($sformatf("clip_flash%0d", i),
                  (((i / 4) % 2) == 0) ? 10'h3FF : 10'h000, 2'd2, 1'b0);
    end
    tick();
    checkOutput("clip_exit", 10'h3FF, 2'd0, 1'b0);
    applyStimulus(10'h001, 1'b0, 4'd0);
    tick();
    checkOutput("clip_meter", 10'h001, 2'd0, 1'b0);

    // Collision: clip edge with a pending request; ack only after CLIP exits.
    applyStimulus(10'h3FF, 1'b1, 4'd6);
    tick();
    checkOutput("coll_edge", 10'h3FF, 2'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick();
      checkOutput($sformatf("coll_flash%0d", i),
                  (((i / 4) % 2) == 0) ? 10'h3FF : 10'h000, 2'd2, 1'b0);
    end
    tick();
    checkOutput("coll_ack", 10'h3FF, 2'd0, 1'b1);
    applyStimulus(10'h3FF, 1'b0, 4'd6);
    tick();
    checkOutput("coll_param", 10'h03F, 2'd1, 1'b0);

    // Async reset at hold count 3, asserted between clock edges.
    tick();
    tick();
    checkOutput("areset_pre", 10'h03F, 2'd1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("areset_now", 10'h000, 2'd0, 1'b0);
    applyStimulus(10'h155, 1'b0, 4'd0);
    tick();
    checkOutput("areset_held", 10'h000, 2'd0, 1'b0);
    reset_n = 1'b1;
    tick();
    checkOutput("areset_meter", 10'h155, 2'd0, 1'b0);
    applyStimulus(10'h0AA, 1'b0, 4'd0);
    tick();
    checkOutput("areset_follow", 10'h0AA, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
